step_ramp_planner: RTL and testbench

- Motion-profile stage directly upstream of the A4988 step-pulse driver.
- Accepts a move command: direction, microstep count and peak speed. Drives the driver's dir_in, speed and run_en with a trapezoidal or triangular acceleration profile.
- Counts rising edges of the driver's step output to track remaining microsteps, and stops exactly on count.

---
 rtl/step_ramp_planner.sv | 200 ++++++++++++++++++++
 tb/tb_step_ramp_planner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ramp_planner.sv
// Speed-profile planner for the A4988 step-pulse driver: trapezoid or triangle, stops on exact step count.
// Define STEP_RAMP_POS_EN to add the signed step-position counter (pos_clear, position).
module step_ramp_planner #(
    parameter int         RAMP_DIV  = 250000,
    parameter logic [9:0] ACCEL     = 10'd8,
    parameter logic [9:0] MIN_SPEED = 10'd16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [15:0]        cmd_steps,
    input  logic [9:0]         cmd_max_speed,
    input  logic               abort,
    input  logic               step_fb,
`ifdef STEP_RAMP_POS_EN
    input  logic               pos_clear,
    output logic signed [31:0] position,
`endif
    output logic               dir,
    output logic [9:0]         speed,
    output logic               run_en,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [15:0]        steps_remaining
);

    localparam int CNT_W = $clog2(RAMP_DIV);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_FINISH
    } state_t;

    state_t      state, state_n;
    logic [CNT_W-1:0] ramp_cnt, cnt_n;
    logic [15:0] accel_steps, accel_n;
    logic [15:0] steps_n;
    logic [9:0]  vmax, vmax_n;
    logic [9:0]  speed_n;
    logic        dir_n, run_en_n, busy_n, done_n, aborted_n;
    logic        fb_q;
    logic        step_edge, active, tick;

    // Widened add so a speed near 1023 clamps to vmax instead of wrapping.
    function automatic logic [9:0] ramp_up(input logic [9:0] cur, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, cur} + {1'b0, ACCEL};
        ramp_up = (sum > {1'b0, lim}) ? lim : sum[9:0];
    endfunction

    function automatic logic [9:0] ramp_down(input logic [9:0] cur);
        logic signed [11:0] diff;
        diff = $signed({2'b00, cur}) - $signed({2'b00, ACCEL});
        ramp_down = (diff < $signed({2'b00, MIN_SPEED})) ? MIN_SPEED : diff[9:0];
    endfunction

    assign step_edge = step_fb && !fb_q;
    assign active    = (state == ST_ACCEL) || (state == ST_CRUISE) || (state == ST_DECEL);
    assign tick      = active && (ramp_cnt == TICK_AT);
    assign cmd_ready = (state == ST_IDLE);

    always_comb begin
        state_n   = state;
        dir_n     = dir;
        speed_n   = speed;
        run_en_n  = run_en;
        busy_n    = busy;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        steps_n   = steps_remaining;
        accel_n   = accel_steps;
        vmax_n    = vmax;
        cnt_n     = '0;

        case (state)
            ST_IDLE: begin
                speed_n  = '0;
                run_en_n = 1'b0;
                busy_n   = 1'b0;
                if (cmd_valid) begin
                    dir_n   = cmd_dir;
                    steps_n = cmd_steps;
                    vmax_n  = (cmd_max_speed < MIN_SPEED) ? MIN_SPEED : cmd_max_speed;
                    accel_n = '0;
                    if (cmd_steps == 16'd0) begin
                        state_n = ST_FINISH;
                        done_n  = 1'b1;
                    end else begin
                        state_n  = ST_ACCEL;
                        speed_n  = MIN_SPEED;
                        run_en_n = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                state_n   = ST_IDLE;
                speed_n   = '0;
                run_en_n  = 1'b0;
                busy_n    = 1'b0;
                aborted_n = abort;
            end

            default: begin
                cnt_n = tick ? '0 : ramp_cnt + 1'b1;
                if (step_edge) begin
                    if (steps_remaining != 16'd0)
                        steps_n = steps_remaining - 16'd1;
                    if ((state == ST_ACCEL) && (accel_steps != 16'hFFFF))
                        accel_n = accel_steps + 16'd1;
                end

                // Braking distance mirrors the distance spent accelerating.
                if (state == ST_ACCEL) begin
                    if (tick)
                        speed_n = ramp_up(speed, vmax);
                    if (steps_remaining <= accel_steps)
                        state_n = ST_DECEL;
                    else if (speed == vmax)
                        state_n = ST_CRUISE;
                end else if (state == ST_CRUISE) begin
                    speed_n = vmax;
                    if (steps_remaining <= accel_steps)
                        state_n = ST_DECEL;
                end else if (tick) begin
                    speed_n = ramp_down(speed);
                end

                if (steps_remaining == 16'd0) begin
                    state_n  = ST_FINISH;
                    speed_n  = '0;
                    run_en_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end

                // Abort leaves steps_remaining untouched so it can be inspected.
                if (abort) begin
                    state_n   = ST_IDLE;
                    speed_n   = '0;
                    run_en_n  = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b0;
                    aborted_n = 1'b1;
                    steps_n   = steps_remaining;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            dir             <= 1'b0;
            speed           <= '0;
            run_en          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            steps_remaining <= '0;
            accel_steps     <= '0;
            vmax            <= '0;
            ramp_cnt        <= '0;
            fb_q            <= 1'b0;
        end else begin
            state           <= state_n;
            dir             <= dir_n;
            speed           <= speed_n;
            run_en          <= run_en_n;
            busy            <= busy_n;
            done            <= done_n;
            aborted         <= aborted_n;
            steps_remaining <= steps_n;
            accel_steps     <= accel_n;
            vmax            <= vmax_n;
            ramp_cnt        <= cnt_n;
            fb_q            <= step_fb;
        end
    end

`ifdef STEP_RAMP_POS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            position <= '0;
        else if (pos_clear)
            position <= '0;
        else if (step_edge && busy)
            position <= dir ? position + 32'sd1 : position - 32'sd1;
    end
`endif

endmodule

// File: tb/tb_step_ramp_planner.sv
// Randomized bench for step_ramp_planner against a cycle-level reference model of the motion profile.
module tb_step_ramp_planner;

    localparam int DIV   = 100;
    localparam int ACC   = 8;
    localparam int VMIN  = 16;
    localparam int P_IDLE = 0, P_ACCEL = 1, P_CRUISE = 2, P_DECEL = 3, P_FINISH = 4;

    logic        clock = 1'b0;
    logic        reset_n, cmd_valid, cmd_dir, abort, step_fb;
    logic [15:0] cmd_steps;
    logic [9:0]  cmd_max_speed;
    logic        cmd_ready, dir, run_en, busy, done, aborted;
    logic [9:0]  speed;
    logic [15:0] steps_remaining;
`ifdef STEP_RAMP_POS_EN
    logic               pos_clear;
    logic signed [31:0] position;
    int                 m_pos;
`endif

    int checks = 0, errors = 0;
    int m_ph, m_speed, m_rem, m_acc, m_vmax, m_cnt;
    bit m_dir, m_run, m_busy, m_done, m_aborted, m_fbq;
    int gap, edges_issued, done_cnt, aborted_cnt, peak, m_peak;

    step_ramp_planner #(.RAMP_DIV(DIV), .ACCEL(10'd8), .MIN_SPEED(10'd16)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_max_speed(cmd_max_speed),
        .abort(abort), .step_fb(step_fb),
`ifdef STEP_RAMP_POS_EN
        .pos_clear(pos_clear), .position(position),
`endif
        .dir(dir), .speed(speed), .run_en(run_en), .busy(busy), .done(done),
        .aborted(aborted), .steps_remaining(steps_remaining)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return {cmd_ready, dir, run_en, busy, done, aborted, speed, steps_remaining};
    endfunction

    function automatic logic [31:0] model_pack();
        return {(m_ph == P_IDLE), m_dir, m_run, m_busy, m_done, m_aborted, 10'(m_speed), 16'(m_rem)};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_speed = 0; m_rem = 0; m_acc = 0; m_vmax = 0; m_cnt = 0;
        m_dir = 0; m_run = 0; m_busy = 0; m_done = 0; m_aborted = 0; m_fbq = 0;
`ifdef STEP_RAMP_POS_EN
        m_pos = 0;
`endif
    endtask

    // One clock edge of the profile rules, using the inputs present at that edge.
    task automatic model_edge();
        bit e, t;
        int o_rem, o_acc, o_spd, o_ph;
        bit o_busy;
        e = step_fb && !m_fbq;
        m_fbq = step_fb;
        o_rem = m_rem; o_acc = m_acc; o_spd = m_speed; o_ph = m_ph; o_busy = m_busy;
        m_done = 0; m_aborted = 0;
`ifdef STEP_RAMP_POS_EN
        if (pos_clear) m_pos = 0;
        else if (e && o_busy) m_pos = m_dir ? m_pos + 1 : m_pos - 1;
`endif
        if (o_ph == P_IDLE) begin
            if (cmd_valid) begin
                m_dir = cmd_dir; m_rem = int'(cmd_steps); m_acc = 0; m_cnt = 0;
                m_vmax = (int'(cmd_max_speed) < VMIN) ? VMIN : int'(cmd_max_speed);
                if (cmd_steps == 0) begin
                    m_ph = P_FINISH; m_done = 1;
                end else begin
                    m_ph = P_ACCEL; m_speed = VMIN; m_run = 1; m_busy = 1;
                end
            end
        end else if (o_ph == P_FINISH) begin
            m_ph = P_IDLE; m_aborted = abort;
        end else if (abort) begin
            m_ph = P_IDLE; m_run = 0; m_speed = 0; m_busy = 0; m_aborted = 1;
        end else begin
            t = (m_cnt == DIV - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            if (e) begin
                if (m_rem > 0) m_rem--;
                if (o_ph == P_ACCEL && m_acc < 65535) m_acc++;
            end
            if (o_rem == 0) begin
                m_ph = P_FINISH; m_run = 0; m_speed = 0; m_busy = 0; m_done = 1;
            end else if (o_ph == P_ACCEL) begin
                if (t) m_speed = (o_spd + ACC > m_vmax) ? m_vmax : o_spd + ACC;
                if (o_rem <= o_acc) m_ph = P_DECEL;
                else if (o_spd == m_vmax) m_ph = P_CRUISE;
            end else if (o_ph == P_CRUISE) begin
                m_speed = m_vmax;
                if (o_rem <= o_acc) m_ph = P_DECEL;
            end else if (t) begin
                m_speed = (o_spd - ACC < VMIN) ? VMIN : o_spd - ACC;
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clock);
        if (reset_n) model_edge();
        else model_reset();
        #1;
        check_eq("outs", 64'(dut_pack()), 64'(model_pack()));
`ifdef STEP_RAMP_POS_EN
        check_eq("position", 64'(position), 64'(m_pos));
`endif
        done_cnt += int'(done);
        aborted_cnt += int'(aborted);
        if (int'(speed) > peak) peak = int'(speed);
        if (m_speed > m_peak) m_peak = m_speed;
        if (step_fb) step_fb = 1'b0;
        else if (gap > 0) gap--;
        else if (m_run && m_rem > 0) begin
            step_fb = 1'b1;
            edges_issued++;
            gap = $urandom_range(0, 2);
        end
    endtask

    task automatic run_move(input bit d, input int steps, input int maxs, input int abort_at, input bit noise);
        int cyc, saved_rem;
        bit fired;
        done_cnt = 0; aborted_cnt = 0; peak = 0; m_peak = 0; edges_issued = 0; fired = 0;
        cmd_dir = d; cmd_steps = 16'(steps); cmd_max_speed = 10'(maxs); cmd_valid = 1'b1;
        tick_clk();
        cmd_valid = 1'b0;
        cyc = 0;
        while (m_ph != P_IDLE && cyc < 20000) begin
            if (cyc == abort_at && m_ph != P_FINISH) begin
                abort = 1'b1; step_fb = 1'b0; fired = 1; saved_rem = m_rem;
            end
            if (noise && m_ph != P_FINISH && $urandom_range(0, 15) == 0) begin
                cmd_valid = 1'b1; cmd_dir = ~d;
                cmd_steps = 16'($urandom); cmd_max_speed = 10'($urandom);
            end
            tick_clk();
            if (abort) begin
                check_eq("abort_pulse", 64'(aborted), 64'(1));
                check_eq("abort_run_en", 64'(run_en), 64'(0));
                check_eq("abort_speed", 64'(speed), 64'(0));
                check_eq("abort_done", 64'(done), 64'(0));
                check_eq("abort_frozen", 64'(steps_remaining), 64'(saved_rem));
            end
            cmd_valid = 1'b0; abort = 1'b0;
            cyc++;
        end
        tick_clk();
        check_eq("ready_at_end", 64'(cmd_ready), 64'(1));
        check_eq("done_count", 64'(done_cnt), fired ? 64'(0) : 64'(1));
        check_eq("aborted_count", 64'(aborted_cnt), 64'(fired));
        check_eq("dir_held", 64'(dir), 64'(d));
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0; step_fb = 1'b0;
        cmd_steps = '0; cmd_max_speed = '0; gap = 0;
`ifdef STEP_RAMP_POS_EN
        pos_clear = 1'b0;
`endif
        model_reset();
        tick_clk();
        tick_clk();
        check_eq("reset_state", 64'(dut_pack()), 64'(32'h8000_0000));
        reset_n = 1'b1;
        tick_clk();

        // Trapezoid: 16..64 in steps of 8 every 100 cycles, cruise, mirrored braking.
        run_move(1'b1, 2000, 64, -1, 1'b0);
        check_eq("trap_edges", 64'(edges_issued), 64'(2000));
        check_eq("trap_peak", 64'(peak), 64'(64));
        check_eq("trap_rem", 64'(steps_remaining), 64'(0));

        // Triangle: too short to reach cruise.
        run_move(1'b0, 20, 1023, -1, 1'b1);
        check_eq("tri_edges", 64'(edges_issued), 64'(20));
        check_eq("tri_peak", 64'(peak), 64'(m_peak));

        // Zero-length move.
        cmd_steps = 16'd0; cmd_max_speed = 10'd100; cmd_dir = 1'b1; cmd_valid = 1'b1;
        tick_clk();
        cmd_valid = 1'b0;
        check_eq("zero_done", 64'(done), 64'(1));
        check_eq("zero_run_en", 64'(run_en), 64'(0));
        check_eq("zero_not_ready", 64'(cmd_ready), 64'(0));
        tick_clk();
        check_eq("zero_done_low", 64'(done), 64'(0));
        check_eq("zero_ready", 64'(cmd_ready), 64'(1));

        // Abort while cruising at 32.
        run_move(1'b1, 500, 32, 400, 1'b0);

        // Speed below floor clamps to MIN_SPEED; commands while busy are ignored.
        run_move(1'b1, 30, 5, -1, 1'b1);
        check_eq("clamp_peak", 64'(peak), 64'(16));

        for (int i = 0; i < 6; i++)
            run_move(1'($urandom_range(0, 1)), $urandom_range(0, 300), $urandom_range(0, 150),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(5, 400) : -1, 1'b1);

`ifdef STEP_RAMP_POS_EN
        pos_clear = 1'b1;
        tick_clk();
        pos_clear = 1'b0;
        run_move(1'b0, 10, 40, -1, 1'b0);
        check_eq("pos_minus10", 64'(position), 64'(-10));
`endif

        // Asynchronous reset in the middle of acceleration.
        cmd_steps = 16'd300; cmd_max_speed = 10'd200; cmd_dir = 1'b1; cmd_valid = 1'b1;
        tick_clk();
        cmd_valid = 1'b0;
        repeat (150) tick_clk();
        check_eq("pre_rst_run", 64'(run_en), 64'(1));
        reset_n = 1'b0;
        #1;
        check_eq("rst_async", 64'(dut_pack()), 64'(32'h8000_0000));
        model_reset();
        step_fb = 1'b0;
        tick_clk();
        reset_n = 1'b1;
        tick_clk();
        check_eq("ready_after_rst", 64'(cmd_ready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
